ram_dma_arbiter: RTL and testbench
==================================

# ram_dma_arbiter

Time-slot arbiter that shares the single-port synchronous system RAM (8 KiB, 0x0000–0x1FFF) between the 6502 core and a secondary DMA requester, such as a serial program loader or a debug memory peek/poke engine. The CPU owns the RAM port in the `cpu_clken` cycle and the cycle after it. All other `clk14` cycles go to the DMA port. CPU read data is captured into a holding register, so DMA traffic between CPU enables can never corrupt what the CPU samples. The block sits between the CPU bus / address decode and the RAM instance.

## Interface
Parameters:
- `ADDR_W`, default 13: RAM address width (8 KiB).
- `MIN_PERIOD`, default 4: minimum legal `cpu_clken` period in `clk14` cycles.

Ports:
- `clk14` in 1: master clock. The block has one clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_clken` in 1: CPU enable strobe, one cycle wide and periodic.
- `cpu_ab` in ADDR_W: CPU address, low bits.
- `cpu_ram_cs` in 1: CPU address decodes to RAM.
- `cpu_we` in 1: CPU write.
- `cpu_dbo` in 8: CPU write data.
- `cpu_ram_dout` out 8: held CPU read data. This drives the CPU data-in mux.
- `dma_req` in 1: DMA request, held until acked.
- `dma_we` in 1: 1 = write, 0 = read. Held with `dma_req`.
- `dma_addr` in ADDR_W: DMA address. Held with `dma_req`.
- `dma_wdata` in 8: DMA write data. Held with `dma_req`.
- `dma_ack` out 1: grant pulse. The access is issued to RAM in this cycle.
- `dma_rvalid` out 1: one-cycle pulse; `dma_rdata` is valid.
- `dma_rdata` out 8: registered DMA read data, held until the next read.
- `ram_addr` out ADDR_W: to RAM.
- `ram_we` out 1: to RAM.
- `ram_din` out 8: to RAM.
- `ram_dout` in 8: from RAM, one cycle after address.
- `clken_err` out 1: sticky flag, `cpu_clken` period < MIN_PERIOD.

## Operation
- Internal `clken_d1` is `cpu_clken` delayed one cycle. `clken_d2` is `clken_d1` delayed one cycle.
- Slot A (`cpu_clken`=1):
  - RAM port = CPU.
  - `ram_we = cpu_we & cpu_ram_cs`, `ram_addr = cpu_ab`, `ram_din = cpu_dbo`.
- Slot B (`clken_d1`=1): RAM port = CPU read, `ram_addr = cpu_ab`, `ram_we = 0`.
- Capture: in the `clken_d2` cycle, `cpu_ram_dout <= ram_dout` at the clock edge. Otherwise it holds.
- Free slot (neither A nor B):
  - If `dma_req`=1: `dma_ack`=1 combinationally, `ram_addr = dma_addr`, `ram_we = dma_we`, `ram_din = dma_wdata`.
  - If `dma_req`=0: `ram_we = 0`, and `ram_addr` holds the CPU address.
- CPU always wins. A DMA request that coincides with Slot A or B waits with no ack. There is no DMA starvation, because every period has at least `MIN_PERIOD - 2` free slots.
- Read return pipeline:
  - `rd_p1 <= ack & ~dma_we`.
  - When `rd_p1`: `dma_rdata <= ram_dout` and `dma_rvalid <= 1`. Otherwise `dma_rvalid <= 0`.
- Back-to-back DMA accesses in consecutive free cycles are allowed. One access completes per cycle.
- Period checker:
  - A counter saturates at MIN_PERIOD, clears to 1 on the cycle after `cpu_clken`, and increments otherwise.
  - A `cpu_clken` that arrives while the counter < MIN_PERIOD sets `clken_err`.
  - The first `cpu_clken` after reset is exempt: the counter resets to MIN_PERIOD.
  - `clken_err` clears only on `rst`.

## Timing
- Reset values (async, immediate):
  - `dma_ack`=0, `ram_we`=0 (forced 0 for the whole time `rst` is high), `dma_rvalid`=0.
  - `dma_rdata`=0x00, `cpu_ram_dout`=0x00, `clken_err`=0.
  - `clken_d1`/`clken_d2`=0, `rd_p1`=0.
- Reset asserted mid-read drops the pending `dma_rvalid`. The requester must re-issue.
- DMA write: committed at the rising edge ending the ack cycle. Latency from ack = 0.
- DMA read: ack in cycle N, RAM output in N+1, `dma_rvalid`/`dma_rdata` in N+2. Latency = 2.
- CPU read: address in Slot B (cycle E+1), RAM output in E+2, `cpu_ram_dout` valid from E+3 until the next capture.
  - The next CPU sample at E+P requires P ≥ 4.
- CPU write: committed at the edge ending Slot A. A DMA write to the same address in a later free cycle overwrites it (last-writer-wins by time).
- If `cpu_clken` and `dma_req` coincide, the CPU gets the port, `dma_ack`=0, and the DMA is granted in the first free cycle, at E+2 at the earliest.

## Test plan
- Write and read, no DMA: `cpu_clken` every 14 cycles; CPU writes 0xA5 to 0x0123, then reads 0x0123 → `cpu_ram_dout`=0xA5 from E+3; `dma_ack` never pulses.
- Collision: `dma_req` (read, 0x0123) raised in a Slot A cycle → no ack in Slots A/B; ack at E+2, `dma_rvalid` at E+4 with `dma_rdata`=0xA5.
- DMA burst does not disturb the CPU: DMA writes 0x00–0x0B to 0x0100–0x010B back-to-back in free slots; the CPU reads 0x0050 (preloaded 0x3C) in the same period → `cpu_ram_dout`=0x3C at the next `cpu_clken`, and a later DMA read of 0x0107 returns 0x07.
- Reset mid-read: `rst` asserted in cycle N+1 after a DMA read ack → `dma_rvalid` stays 0, `dma_rdata`=0x00, `ram_we`=0 during reset; normal slots resume after release.
- Period violation: `cpu_clken` pulses 3 cycles apart → `clken_err`=1 and stays 1 across later legal periods until `rst`; a 4-cycle spacing from reset never sets it.

Source files
------------

// File: rtl/ram_dma_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the RAM instance and ram_dma_arbiter.
// The arbiter takes the slave view; the surrounding system (CPU, DMA engine, RAM) takes the master view.
interface ram_dma_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              cpu_clken;
  logic [ADDR_W-1:0] cpu_ab;
  logic              cpu_ram_cs;
  logic              cpu_we;
  logic [7:0]        cpu_dbo;
  logic [7:0]        cpu_ram_dout;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [7:0]        dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic              clken_err;

  modport slave (
    input  cpu_clken, cpu_ab, cpu_ram_cs, cpu_we, cpu_dbo,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_dout,
    output cpu_ram_dout, dma_ack, dma_rvalid, dma_rdata,
    output ram_addr, ram_we, ram_din, clken_err
  );

  modport master (
    output cpu_clken, cpu_ab, cpu_ram_cs, cpu_we, cpu_dbo,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_dout,
    input  cpu_ram_dout, dma_ack, dma_rvalid, dma_rdata,
    input  ram_addr, ram_we, ram_din, clken_err
  );
endinterface

// File: rtl/ram_dma_arbiter.sv
// Time-slot arbiter for the single-port system RAM: the CPU owns the enable cycle and the
// one after it, every other clk14 cycle is offered to the DMA requester.
module ram_dma_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int MIN_PERIOD = 4
) (
  input  logic            clk14,
  input  logic            rst,
  ram_dma_arbiter_if.slave bus
);

  localparam logic [1:0] SLOT_A    = 2'd0;
  localparam logic [1:0] SLOT_B    = 2'd1;
  localparam logic [1:0] SLOT_FREE = 2'd2;

  localparam int              CNT_W   = $clog2(MIN_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_PERIOD);

  logic              clken_d1;
  logic              clken_d2;
  logic              rd_p1;
  logic [1:0]        slot;
  logic              dma_grant;
  logic [ADDR_W-1:0] addr_mux;
  logic [7:0]        din_mux;
  logic              we_mux;
  logic [CNT_W-1:0]  period_cnt;

  always_comb begin
    slot = SLOT_FREE;
    if (bus.cpu_clken)
      slot = SLOT_A;
    else if (clken_d1)
      slot = SLOT_B;
  end

  assign dma_grant = (slot == SLOT_FREE) && bus.dma_req && !rst;

  // An idle free slot keeps the CPU address on the RAM so the port never floats.
  always_comb begin
    addr_mux = bus.cpu_ab;
    din_mux  = bus.cpu_dbo;
    we_mux   = 1'b0;
    case (slot)
      SLOT_A: we_mux = bus.cpu_we & bus.cpu_ram_cs;
      SLOT_B: we_mux = 1'b0;
      default: begin
        if (dma_grant) begin
          addr_mux = bus.dma_addr;
          din_mux  = bus.dma_wdata;
          we_mux   = bus.dma_we;
        end
      end
    endcase
    if (rst)
      we_mux = 1'b0;
  end

  assign bus.ram_addr = addr_mux;
  assign bus.ram_din  = din_mux;
  assign bus.ram_we   = we_mux;
  assign bus.dma_ack  = dma_grant;

  // RAM output lags its address by one cycle, so both read paths capture two cycles after issue.
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      clken_d1         <= 1'b0;
      clken_d2         <= 1'b0;
      rd_p1            <= 1'b0;
      bus.dma_rvalid   <= 1'b0;
      bus.dma_rdata    <= 8'h00;
      bus.cpu_ram_dout <= 8'h00;
    end else begin
      clken_d1       <= bus.cpu_clken;
      clken_d2       <= clken_d1;
      rd_p1          <= dma_grant & ~bus.dma_we;
      bus.dma_rvalid <= rd_p1;
      if (rd_p1)
        bus.dma_rdata <= bus.ram_dout;
      if (clken_d2)
        bus.cpu_ram_dout <= bus.ram_dout;
    end
  end

  // Counter starts saturated so the first enable after reset never flags a short period.
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      period_cnt    <= CNT_MAX;
      bus.clken_err <= 1'b0;
    end else if (bus.cpu_clken) begin
      period_cnt <= CNT_W'(1);
      if (period_cnt < CNT_MAX)
        bus.clken_err <= 1'b1;
    end else if (period_cnt < CNT_MAX) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Randomised and directed bench for ram_dma_arbiter with a behavioural RAM and a
// reference memory model that tracks CPU and DMA writes in time order.
module tb_ram_dma_arbiter;

  localparam int AW   = 13;
  localparam int MAXC = 8192;

  logic clk14 = 1'b0;
  logic rst;

  ram_dma_arbiter_if #(.ADDR_W(AW)) bus ();

  ram_dma_arbiter #(.ADDR_W(AW), .MIN_PERIOD(4)) dut (
    .clk14 (clk14),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk14 = ~clk14;

  // Synchronous single-port RAM, read-before-write, one cycle of read latency.
  logic [7:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk14) begin
    if (bus.ram_we)
      ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk14);
    cyc++;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } dma_op_t;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    exp;
  } ack_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rv_t;

  logic [7:0] ref_mem [int];
  dma_op_t    req_q [$];
  ack_t       ack_log [$];
  rv_t        rv_log [$];
  bit         ce_tr  [MAXC];
  bit         req_tr [MAXC];
  bit         ack_tr [MAXC];
  logic [7:0] exp_cpu = 8'h00;

  // DMA requester: holds each queued op until acked, then presents the next one back-to-back.
  initial begin
    bit      done;
    dma_op_t cur;
    ack_t    a;
    rv_t     r;
    done          = 1'b0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = 8'h00;
    forever begin
      @(posedge clk14);
      #1;
      if (done) begin
        bus.dma_req = 1'b0;
        done        = 1'b0;
      end
      if (!bus.dma_req && req_q.size() > 0) begin
        cur           = req_q.pop_front();
        bus.dma_we    = cur.we;
        bus.dma_addr  = cur.addr;
        bus.dma_wdata = cur.wdata;
        bus.dma_req   = 1'b1;
      end
      @(negedge clk14);
      if (cyc < MAXC) begin
        ce_tr[cyc]  = bus.cpu_clken;
        req_tr[cyc] = bus.dma_req;
        ack_tr[cyc] = bus.dma_ack;
      end
      if (bus.dma_rvalid) begin
        r.cyc  = cyc;
        r.data = bus.dma_rdata;
        rv_log.push_back(r);
      end
      if (bus.dma_req && bus.dma_ack) begin
        a.cyc  = cyc;
        a.we   = cur.we;
        a.addr = cur.addr;
        if (cur.we) begin
          ref_mem[int'(cur.addr)] = cur.wdata;
          a.exp = cur.wdata;
        end else begin
          a.exp = ref_mem.exists(int'(cur.addr)) ? ref_mem[int'(cur.addr)] : 8'h00;
        end
        ack_log.push_back(a);
        done = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One CPU period: enable in the first cycle, address held for the whole period.
  task automatic cpu_period(input int period, input logic we, input logic [AW-1:0] addr,
                            input logic [7:0] wdata, output int e_cyc);
    logic [7:0] nxt;
    @(posedge clk14);
    #1;
    bus.cpu_clken  = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_ram_cs = 1'b1;
    bus.cpu_ab     = addr;
    bus.cpu_dbo    = wdata;
    e_cyc          = cyc;
    @(negedge clk14);
    total++;
    if (bus.ram_we !== we) begin
      bad++;
      $display("[TB] FAIL slotA_ram_we @%0d: got %b want %b", cyc, bus.ram_we, we);
    end
    total++;
    if (bus.dma_ack !== 1'b0) begin
      bad++;
      $display("[TB] FAIL slotA_no_ack @%0d: got %b want 0", cyc, bus.dma_ack);
    end
    if (we)
      ref_mem[int'(addr)] = wdata;
    nxt = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
    for (int k = 1; k < period; k++) begin
      @(posedge clk14);
      #1;
      bus.cpu_clken = 1'b0;
      @(negedge clk14);
      if (k == 1) begin
        total++;
        if (bus.ram_we !== 1'b0 || bus.dma_ack !== 1'b0) begin
          bad++;
          $display("[TB] FAIL slotB_quiet @%0d: got we=%b ack=%b want 0/0", cyc, bus.ram_we, bus.dma_ack);
        end
        total++;
        if (bus.ram_addr !== addr) begin
          bad++;
          $display("[TB] FAIL slotB_addr @%0d: got %h want %h", cyc, bus.ram_addr, addr);
        end
      end
      if (k == 2) begin
        total++;
        if (bus.cpu_ram_dout !== exp_cpu) begin
          bad++;
          $display("[TB] FAIL cpu_dout_hold @%0d: got %h want %h", cyc, bus.cpu_ram_dout, exp_cpu);
        end
      end
      if (k == 3) begin
        total++;
        if (bus.cpu_ram_dout !== nxt) begin
          bad++;
          $display("[TB] FAIL cpu_dout_new @%0d: got %h want %h", cyc, bus.cpu_ram_dout, nxt);
        end
      end
    end
    exp_cpu = nxt;
  endtask

  task automatic test_reset();
    dma_op_t op;
    op = '{we: 1'b1, addr: 13'h0050, wdata: 8'h3C};
    req_q.push_back(op);
    rst            = 1'b1;
    bus.cpu_clken  = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_ram_cs = 1'b1;
    bus.cpu_ab     = 13'h0050;
    bus.cpu_dbo    = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk14);
      #1;
      @(negedge clk14);
      total++;
      if (bus.ram_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_ram_we: got %b want 0", bus.ram_we); end
      total++;
      if (bus.dma_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_dma_ack: got %b want 0", bus.dma_ack); end
      total++;
      if (bus.dma_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 0", bus.dma_rvalid); end
      total++;
      if (bus.dma_rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00", bus.dma_rdata); end
      total++;
      if (bus.cpu_ram_dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_cpu_dout: got %h want 00", bus.cpu_ram_dout); end
      total++;
      if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_clken_err: got %b want 0", bus.clken_err); end
    end
    @(posedge clk14);
    #1;
    rst           = 1'b0;
    bus.cpu_clken = 1'b0;
    bus.cpu_we    = 1'b0;
    exp_cpu       = 8'h00;
    @(negedge clk14);
    total++;
    if (bus.dma_ack !== 1'b1) begin bad++; $display("[TB] FAIL release_ack: got %b want 1", bus.dma_ack); end
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 13'h0050) begin
      bad++;
      $display("[TB] FAIL release_dma_write: got we=%b addr=%h want 1/0050", bus.ram_we, bus.ram_addr);
    end
  endtask

  task automatic test_cpu_rw();
    int e;
    int start;
    int n;
    start = cyc + 1;
    cpu_period(14, 1'b1, 13'h0123, 8'hA5, e);
    cpu_period(14, 1'b0, 13'h0123, 8'h00, e);
    cpu_period(14, 1'b0, 13'h0050, 8'h00, e);
    n = 0;
    for (int c = start; c <= cyc; c++)
      if (ack_tr[c]) n++;
    total++;
    if (n !== 0) begin bad++; $display("[TB] FAIL cpu_rw_no_ack: got %0d acks want 0", n); end
  endtask

  task automatic test_collision();
    dma_op_t op;
    int e, na, ac, nr, rc;
    logic [7:0] rd;
    op = '{we: 1'b0, addr: 13'h0123, wdata: 8'h00};
    req_q.push_back(op);
    cpu_period(14, 1'b0, 13'h0123, 8'h00, e);
    na = 0; ac = -1;
    foreach (ack_log[i])
      if (ack_log[i].cyc >= e && ack_log[i].cyc < e + 14) begin na++; ac = ack_log[i].cyc; end
    total++;
    if (na !== 1 || ac !== e + 2) begin
      bad++;
      $display("[TB] FAIL collision_ack: got n=%0d at E+%0d want n=1 at E+2", na, ac - e);
    end
    nr = 0; rc = -1; rd = 8'h00;
    foreach (rv_log[i])
      if (rv_log[i].cyc >= e && rv_log[i].cyc < e + 14) begin nr++; rc = rv_log[i].cyc; rd = rv_log[i].data; end
    total++;
    if (nr !== 1 || rc !== e + 4) begin
      bad++;
      $display("[TB] FAIL collision_rvalid: got n=%0d at E+%0d want n=1 at E+4", nr, rc - e);
    end
    total++;
    if (rd !== 8'hA5) begin bad++; $display("[TB] FAIL collision_rdata: got %h want a5", rd); end
  endtask

  task automatic test_burst();
    dma_op_t op;
    int e, e2, hit, nr;
    logic [7:0] rd;
    for (int i = 0; i < 12; i++) begin
      op = '{we: 1'b1, addr: 13'h0100 + 13'(i), wdata: 8'(i)};
      req_q.push_back(op);
    end
    cpu_period(14, 1'b0, 13'h0050, 8'h00, e);
    op = '{we: 1'b0, addr: 13'h0107, wdata: 8'h00};
    req_q.push_back(op);
    cpu_period(14, 1'b0, 13'h0050, 8'h00, e2);
    for (int i = 0; i < 12; i++) begin
      hit = -1;
      foreach (ack_log[j])
        if (ack_log[j].cyc == e + 2 + i) hit = j;
      total++;
      if (hit < 0) begin
        bad++;
        $display("[TB] FAIL burst_ack_%0d: got no ack at E+%0d want write to %h", i, i + 2, 13'h0100 + 13'(i));
      end else if (ack_log[hit].addr !== 13'h0100 + 13'(i) || ack_log[hit].we !== 1'b1) begin
        bad++;
        $display("[TB] FAIL burst_ack_%0d: got addr %h we %b want %h 1", i, ack_log[hit].addr,
                 ack_log[hit].we, 13'h0100 + 13'(i));
      end
    end
    nr = 0; rd = 8'h00;
    foreach (rv_log[i])
      if (rv_log[i].cyc == e2 + 4) begin nr++; rd = rv_log[i].data; end
    total++;
    if (nr !== 1 || rd !== 8'h07) begin
      bad++;
      $display("[TB] FAIL burst_readback: got n=%0d data %h want n=1 data 07", nr, rd);
    end
  endtask

  task automatic test_reset_midread();
    dma_op_t op;
    bit got;
    int n_ack, e, nr;
    op = '{we: 1'b0, addr: 13'h0107, wdata: 8'h00};
    req_q.push_back(op);
    got = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk14);
      #1;
      bus.cpu_clken = 1'b0;
      bus.cpu_we    = 1'b0;
      @(negedge clk14);
      if (bus.dma_ack) begin
        got   = 1'b1;
        n_ack = cyc;
        break;
      end
    end
    total++;
    if (!got) begin bad++; $display("[TB] FAIL midread_ack: got no ack in 20 cycles want ack"); end
    @(posedge clk14);
    #1;
    rst            = 1'b1;
    bus.cpu_clken  = 1'b1;
    bus.cpu_we     = 1'b1;
    bus.cpu_ram_cs = 1'b1;
    bus.cpu_ab     = 13'h0123;
    bus.cpu_dbo    = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk14);
      total++;
      if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 8'h00) begin
        bad++;
        $display("[TB] FAIL midread_rvalid: got v=%b d=%h want 0/00", bus.dma_rvalid, bus.dma_rdata);
      end
      total++;
      if (bus.ram_we !== 1'b0) begin bad++; $display("[TB] FAIL midread_ram_we: got %b want 0", bus.ram_we); end
      @(posedge clk14);
      #1;
    end
    rst           = 1'b0;
    bus.cpu_clken = 1'b0;
    bus.cpu_we    = 1'b0;
    exp_cpu       = 8'h00;
    @(negedge clk14);
    cpu_period(6, 1'b0, 13'h0123, 8'h00, e);
    nr = 0;
    foreach (rv_log[i])
      if (rv_log[i].cyc >= n_ack) nr++;
    total++;
    if (nr !== 0) begin bad++; $display("[TB] FAIL midread_dropped: got %0d rvalid pulses want 0", nr); end
    total++;
    if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL midread_err: got %b want 0", bus.clken_err); end
  endtask

  task automatic test_period();
    int e;
    for (int k = 0; k < 3; k++) begin
      cpu_period(4, 1'b0, 13'h0050, 8'h00, e);
      total++;
      if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL period4_err_%0d: got %b want 0", k, bus.clken_err); end
    end
    cpu_period(3, 1'b0, 13'h0050, 8'h00, e);
    total++;
    if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL period_before_short: got %b want 0", bus.clken_err); end
    cpu_period(4, 1'b0, 13'h0050, 8'h00, e);
    total++;
    if (bus.clken_err !== 1'b1) begin bad++; $display("[TB] FAIL period_short_sets: got %b want 1", bus.clken_err); end
    for (int k = 0; k < 2; k++) begin
      cpu_period(8, 1'b0, 13'h0050, 8'h00, e);
      total++;
      if (bus.clken_err !== 1'b1) begin bad++; $display("[TB] FAIL period_sticky_%0d: got %b want 1", k, bus.clken_err); end
    end
    @(posedge clk14);
    #1;
    rst           = 1'b1;
    bus.cpu_clken = 1'b0;
    @(negedge clk14);
    total++;
    if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL period_reset_clears: got %b want 0", bus.clken_err); end
    @(posedge clk14);
    #1;
    rst     = 1'b0;
    exp_cpu = 8'h00;
    @(negedge clk14);
    for (int k = 0; k < 4; k++) begin
      cpu_period(4, 1'b0, 13'h0050, 8'h00, e);
      total++;
      if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL period_from_reset_%0d: got %b want 0", k, bus.clken_err); end
    end
  endtask

  task automatic test_random();
    localparam logic [AW-1:0] BASE = 13'h1FF0;
    dma_op_t op;
    int e, start, stop, nd, hit, nrd, nrv;
    bit exp_a;
    for (int i = 0; i < 16; i++) begin
      op = '{we: 1'b1, addr: BASE + 13'(i), wdata: 8'($urandom)};
      req_q.push_back(op);
    end
    cpu_period(20, 1'b0, 13'h0050, 8'h00, e);
    start = cyc + 1;
    for (int it = 0; it < 40; it++) begin
      nd = int'($urandom_range(0, 2));
      for (int j = 0; j < nd; j++) begin
        op.we    = 1'($urandom_range(0, 1));
        op.addr  = BASE + 13'($urandom_range(0, 15));
        op.wdata = 8'($urandom);
        req_q.push_back(op);
      end
      cpu_period(int'($urandom_range(4, 9)), 1'($urandom_range(0, 1)),
                 BASE + 13'($urandom_range(0, 15)), 8'($urandom), e);
    end
    cpu_period(20, 1'b0, BASE, 8'h00, e);
    stop = cyc;
    for (int c = start; c <= stop; c++) begin
      exp_a = req_tr[c] && !ce_tr[c] && !ce_tr[c-1];
      total++;
      if (ack_tr[c] !== exp_a) begin
        bad++;
        $display("[TB] FAIL rand_ack @%0d: got %b want %b", c, ack_tr[c], exp_a);
      end
    end
    nrd = 0;
    foreach (ack_log[i]) begin
      if (ack_log[i].cyc >= start && ack_log[i].cyc <= stop && !ack_log[i].we) begin
        nrd++;
        hit = -1;
        foreach (rv_log[j])
          if (rv_log[j].cyc == ack_log[i].cyc + 2) hit = j;
        total++;
        if (hit < 0) begin
          bad++;
          $display("[TB] FAIL rand_rvalid @%0d: got none want data %h", ack_log[i].cyc + 2, ack_log[i].exp);
        end else if (rv_log[hit].data !== ack_log[i].exp) begin
          bad++;
          $display("[TB] FAIL rand_rdata @%0d: got %h want %h", rv_log[hit].cyc, rv_log[hit].data, ack_log[i].exp);
        end
      end
    end
    nrv = 0;
    foreach (rv_log[i])
      if (rv_log[i].cyc >= start + 2 && rv_log[i].cyc <= stop) nrv++;
    total++;
    if (nrv !== nrd) begin bad++; $display("[TB] FAIL rand_rvalid_count: got %0d want %0d", nrv, nrd); end
    total++;
    if (bus.clken_err !== 1'b0) begin bad++; $display("[TB] FAIL rand_err: got %b want 0", bus.clken_err); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.cpu_clken  = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_ram_cs = 1'b0;
    bus.cpu_ab     = '0;
    bus.cpu_dbo    = 8'h00;
    $display("[TB] starting ram_dma_arbiter bench");
    test_reset();
    test_cpu_rw();
    test_collision();
    test_burst();
    test_reset_midread();
    test_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
